// File: rtl/tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tx_fifo_ctrl
//   Pointer and flow controller for the TX FIFO that sits between the packet
//   builder (writer) and the serial transmitter (reader). The storage RAM is
//   external; this block owns the head/tail pointers, derives occupancy and
//   full/empty, gates the write/read strobes, and decides when the transmitter
//   may start draining (threshold reached, FIFO full, or end of packet).
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   wr_req/wr_last  writer presents a byte; wr_last marks the last byte of a packet
//   rd_req          transmitter requests a pop
//   flush           discard the FIFO contents (one-cycle FLUSH state)
//   err_clr         clear the sticky error flags
//   wr_en, wr_ptr   write strobe and tail pointer for the storage RAM
//   rd_en, rd_ptr   read-advance strobe and head pointer (data sits at rd_ptr)
//   full, empty     derived from pointers and wrap-toggle bits
//   count           registered occupancy, 0..DEPTH
//   tx_start        one-cycle pulse in the first cycle of SEND
//   tx_active       high while the FSM is in SEND
//   overflow_err    sticky: write requested while full
//   underflow_err   sticky: read requested while empty or outside SEND
// -----------------------------------------------------------------------------
module tx_fifo_ctrl #(
    parameter int DEPTH  = 6,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 3,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             wr_last,
    input  logic             rd_req,
    input  logic             flush,
    input  logic             err_clr,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             rd_en,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             tx_start,
    output logic             tx_active,
    output logic             overflow_err,
    output logic             underflow_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

    state_t           state;
    logic             wr_tog;
    logic             rd_tog;
    logic             eop_pend;
    logic [CNT_W-1:0] count_nxt;
    logic             eop_now;
    logic             go_send;
    logic             drained;

    // Equal pointers mean either empty or full; the wrap toggles tell them apart.
    assign empty = (wr_ptr == rd_ptr) && (wr_tog == rd_tog);
    assign full  = (wr_ptr == rd_ptr) && (wr_tog != rd_tog);

    // Strobes are combinational so the writer/reader see acceptance in the same
    // cycle; they are forced low while reset is held.
    assign wr_en = wr_req && !full  && (state != FLUSH) && !rst;
    assign rd_en = rd_req && !empty && (state == SEND)  && !rst;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) begin
            count_nxt = count + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_nxt = count - 1'b1;
        end
    end

    // End of packet seen, including a last byte accepted this very cycle.
    assign eop_now = eop_pend || (wr_en && wr_last);
    assign go_send = (count_nxt >= CNT_THRESH) || (count_nxt == CNT_FULL) || eop_now;
    // The pop in this cycle leaves the FIFO empty.
    assign drained = rd_en && (count_nxt == '0);

    // Control FSM with registered tx_start / tx_active.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_start  <= 1'b0;
            tx_active <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (flush) begin
                state     <= FLUSH;
                tx_active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_en) begin
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (go_send) begin
                            state     <= SEND;
                            tx_start  <= 1'b1;
                            tx_active <= 1'b1;
                        end
                    end
                    SEND: begin
                        // Drained: a finished packet returns to IDLE, otherwise
                        // wait in ACCUM for the writer to catch up.
                        if (drained) begin
                            state     <= eop_pend ? IDLE : ACCUM;
                            tx_active <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        tx_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pointers, toggles, occupancy and the end-of-packet marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_tog   <= 1'b0;
            rd_tog   <= 1'b0;
            count    <= '0;
            eop_pend <= 1'b0;
        end else if (state == FLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_tog   <= 1'b0;
            rd_tog   <= 1'b0;
            count    <= '0;
            eop_pend <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_ptr == PTR_LAST) begin
                    wr_ptr <= '0;
                    wr_tog <= ~wr_tog;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (rd_en) begin
                if (rd_ptr == PTR_LAST) begin
                    rd_ptr <= '0;
                    rd_tog <= ~rd_tog;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count <= count_nxt;
            if (wr_en && wr_last) begin
                eop_pend <= 1'b1;
            end else if (state == SEND && drained) begin
                eop_pend <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= (wr_req && full) || (overflow_err && !err_clr);
            underflow_err <= (rd_req && (empty || state != SEND)) || (underflow_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tx_fifo_ctrl
//   Directed bench for tx_fifo_ctrl: threshold hand-over, full/overflow, pointer
//   wrap, end-of-packet drain, simultaneous push/pop, flush, and reset taken in
//   the middle of a SEND burst. Inputs change 1 time unit after the rising edge,
//   strobes are sampled on the falling edge, registers 1 unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_req, wr_last, rd_req, flush, err_clr;
    logic       wr_en, rd_en, full, empty, tx_start, tx_active;
    logic       overflow_err, underflow_err;
    logic [2:0] wr_ptr, rd_ptr, count;

    logic       s_wr_en, s_rd_en;
    int         vectors = 0;
    int         miscompares = 0;

    tx_fifo_ctrl #(.DEPTH(6), .PTR_W(3), .CNT_W(3), .THRESH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_last(wr_last), .rd_req(rd_req), .flush(flush), .err_clr(err_clr),
        .wr_en(wr_en), .wr_ptr(wr_ptr), .rd_en(rd_en), .rd_ptr(rd_ptr),
        .full(full), .empty(empty), .count(count),
        .tx_start(tx_start), .tx_active(tx_active),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus: apply inputs, sample the strobes on the
    // falling edge, return 1 unit after the next rising edge with inputs idle.
    task automatic step(input logic w, input logic l, input logic r, input logic f, input logic c);
        wr_req = w; wr_last = l; rd_req = r; flush = f; err_clr = c;
        @(negedge clk);
        s_wr_en = wr_en;
        s_rd_en = rd_en;
        @(posedge clk);
        #1;
        wr_req = 1'b0; wr_last = 1'b0; rd_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        wr_req = 1'b0; wr_last = 1'b0; rd_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_last = 1'b0; flush = 1'b0; err_clr = 1'b0;
        #3;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        vectors++; if (rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got=%b exp=0", rd_en); end
        @(posedge clk);
        #1;
        wr_req = 1'b0; rd_req = 1'b0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", count); end
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL rst_flags empty=%b full=%b exp 1/0", empty, full); end
        vectors++; if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin miscompares++; $display("FAIL rst_ptrs wr=%0d rd=%0d exp 0/0", wr_ptr, rd_ptr); end
        vectors++; if (tx_start !== 1'b0 || tx_active !== 1'b0) begin miscompares++; $display("FAIL rst_tx start=%b active=%b exp 0/0", tx_start, tx_active); end
        vectors++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin miscompares++; $display("FAIL rst_err ovf=%b udf=%b exp 0/0", overflow_err, underflow_err); end
        rst = 1'b0;
    endtask

    task automatic test_threshold();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++; if (s_wr_en !== 1'b1) begin miscompares++; $display("FAIL thr_wr_en[%0d] got=%b exp=1", i, s_wr_en); end
            vectors++; if (wr_ptr !== 3'(i + 1) || count !== 3'(i + 1)) begin miscompares++; $display("FAIL thr_ptr_cnt[%0d] wr_ptr=%0d count=%0d exp=%0d", i, wr_ptr, count, i + 1); end
            vectors++; if (tx_start !== (i == 3)) begin miscompares++; $display("FAIL thr_tx_start[%0d] got=%b exp=%b", i, tx_start, (i == 3)); end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (tx_start !== 1'b0 || tx_active !== 1'b1) begin miscompares++; $display("FAIL thr_pulse start=%b active=%b exp 0/1", tx_start, tx_active); end
    endtask

    task automatic test_full_overflow();
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (full !== 1'b1 || count !== 3'd6 || wr_ptr !== 3'd0) begin miscompares++; $display("FAIL ovf_full full=%b count=%0d wr_ptr=%0d exp 1/6/0", full, count, wr_ptr); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (s_wr_en !== 1'b0) begin miscompares++; $display("FAIL ovf_wr_en got=%b exp=0", s_wr_en); end
        vectors++; if (overflow_err !== 1'b1 || count !== 3'd6) begin miscompares++; $display("FAIL ovf_err err=%b count=%0d exp 1/6", overflow_err, count); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (rd_ptr !== 3'(i)) begin miscompares++; $display("FAIL ovf_rd_ptr[%0d] got=%0d exp=%0d", i, rd_ptr, i); end
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            vectors++; if (s_rd_en !== 1'b1) begin miscompares++; $display("FAIL ovf_rd_en[%0d] got=%b exp=1", i, s_rd_en); end
        end
        vectors++; if (empty !== 1'b1 || rd_ptr !== 3'd0 || tx_active !== 1'b0) begin miscompares++; $display("FAIL ovf_drain empty=%b rd_ptr=%0d active=%b exp 1/0/0", empty, rd_ptr, tx_active); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (s_rd_en !== 1'b0 || underflow_err !== 1'b1 || overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_udf rd_en=%b udf=%b ovf=%b exp 0/1/1", s_rd_en, underflow_err, overflow_err); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 6; i++) begin
                vectors++; if (wr_ptr !== 3'(i)) begin miscompares++; $display("FAIL wrap%0d_wr_ptr[%0d] got=%0d exp=%0d", w, i, wr_ptr, i); end
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL wrap%0d_full full=%b empty=%b exp 1/0", w, full, empty); end
            for (int i = 0; i < 6; i++) begin
                vectors++; if (rd_ptr !== 3'(i)) begin miscompares++; $display("FAIL wrap%0d_rd_ptr[%0d] got=%0d exp=%0d", w, i, rd_ptr, i); end
                step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL wrap%0d_empty empty=%b full=%b exp 1/0", w, empty, full); end
        end
        vectors++; if (count !== 3'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin miscompares++; $display("FAIL wrap_end count=%0d wr=%0d rd=%0d exp 0/0/0", count, wr_ptr, rd_ptr); end
        vectors++; if (underflow_err !== 1'b0 || overflow_err !== 1'b0) begin miscompares++; $display("FAIL wrap_err udf=%b ovf=%b exp 0/0", underflow_err, overflow_err); end
    endtask

    task automatic test_eop();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++; if (tx_start !== 1'b1 || count !== 3'd2) begin miscompares++; $display("FAIL eop_send start=%b count=%0d exp 1/2", tx_start, count); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (tx_active !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL eop_idle active=%b empty=%b exp 0/1", tx_active, empty); end
        // eop_pend must be gone: one plain byte has to sit in ACCUM, not start SEND.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (tx_active !== 1'b0 || count !== 3'd1) begin miscompares++; $display("FAIL eop_cleared active=%b count=%0d exp 0/1", tx_active, count); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (count !== 3'd3 || rd_ptr !== 3'd1 || wr_ptr !== 3'd4) begin miscompares++; $display("FAIL pp_pre count=%0d rd=%0d wr=%0d exp 3/1/4", count, rd_ptr, wr_ptr); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (s_wr_en !== 1'b1 || s_rd_en !== 1'b1) begin miscompares++; $display("FAIL pp_strobes wr_en=%b rd_en=%b exp 1/1", s_wr_en, s_rd_en); end
        vectors++; if (count !== 3'd3 || wr_ptr !== 3'd5 || rd_ptr !== 3'd2 || tx_active !== 1'b1) begin miscompares++; $display("FAIL pp_both count=%0d wr=%0d rd=%0d active=%b exp 3/5/2/1", count, wr_ptr, rd_ptr, tx_active); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (full !== 1'b1 || count !== 3'd6 || wr_ptr !== 3'd2) begin miscompares++; $display("FAIL pp_full full=%b count=%0d wr=%0d exp 1/6/2", full, count, wr_ptr); end
        // Push while full is rejected even though a pop happens in the same cycle.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (s_wr_en !== 1'b0 || s_rd_en !== 1'b1) begin miscompares++; $display("FAIL pp_full_strobes wr_en=%b rd_en=%b exp 0/1", s_wr_en, s_rd_en); end
        vectors++; if (count !== 3'd5 || wr_ptr !== 3'd2 || rd_ptr !== 3'd3 || overflow_err !== 1'b1) begin miscompares++; $display("FAIL pp_full_pop count=%0d wr=%0d rd=%0d ovf=%b exp 5/2/3/1", count, wr_ptr, rd_ptr, overflow_err); end
    endtask

    task automatic test_flush();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (s_rd_en !== 1'b0 || underflow_err !== 1'b1) begin miscompares++; $display("FAIL fl_udf rd_en=%b udf=%b exp 0/1", s_rd_en, underflow_err); end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (count !== 3'd5 || tx_active !== 1'b1) begin miscompares++; $display("FAIL fl_pre count=%0d active=%b exp 5/1", count, tx_active); end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++; if (tx_active !== 1'b0) begin miscompares++; $display("FAIL fl_enter active=%b exp 0", tx_active); end
        // In the FLUSH cycle no strobe may be issued.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++; if (s_wr_en !== 1'b0 || s_rd_en !== 1'b0) begin miscompares++; $display("FAIL fl_strobes wr_en=%b rd_en=%b exp 0/0", s_wr_en, s_rd_en); end
        vectors++; if (count !== 3'd0 || empty !== 1'b1 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin miscompares++; $display("FAIL fl_clear count=%0d empty=%b wr=%0d rd=%0d exp 0/1/0/0", count, empty, wr_ptr, rd_ptr); end
        vectors++; if (underflow_err !== 1'b1 || overflow_err !== 1'b0) begin miscompares++; $display("FAIL fl_err udf=%b ovf=%b exp 1/0", underflow_err, overflow_err); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (count !== 3'd1 || wr_ptr !== 3'd1 || tx_active !== 1'b0) begin miscompares++; $display("FAIL fl_idle count=%0d wr=%0d active=%b exp 1/1/0", count, wr_ptr, tx_active); end
        // Set wins over a same-cycle clear; a plain clear then drops the flag.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vectors++; if (underflow_err !== 1'b1) begin miscompares++; $display("FAIL fl_set_wins udf=%b exp 1", underflow_err); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (underflow_err !== 1'b0) begin miscompares++; $display("FAIL fl_err_clr udf=%b exp 0", underflow_err); end
    endtask

    task automatic test_reset_mid_send();
        apply_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (tx_active !== 1'b1 || underflow_err !== 1'b1) begin miscompares++; $display("FAIL mid_pre active=%b udf=%b exp 1/1", tx_active, underflow_err); end
        wr_req = 1'b1; rd_req = 1'b1;
        #3 rst = 1'b1;
        #2;
        vectors++; if (wr_en !== 1'b0 || rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_strobes wr_en=%b rd_en=%b exp 0/0", wr_en, rd_en); end
        vectors++; if (count !== 3'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL mid_ptrs count=%0d wr=%0d rd=%0d empty=%b full=%b exp 0/0/0/1/0", count, wr_ptr, rd_ptr, empty, full); end
        vectors++; if (tx_active !== 1'b0 || tx_start !== 1'b0 || underflow_err !== 1'b0 || overflow_err !== 1'b0) begin miscompares++; $display("FAIL mid_ctrl active=%b start=%b udf=%b ovf=%b exp 0/0/0/0", tx_active, tx_start, underflow_err, overflow_err); end
        wr_req = 1'b0; rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_full_overflow();
        test_wrap();
        test_eop();
        test_push_pop();
        test_flush();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
